seq_divider: RTL and testbench

Multi-cycle 64-bit integer divider that sits beside the single-cycle ALU in the EX stage and handles UDIV/SDIV. It takes a start pulse with dividend, divisor and signedness and computes one quotient bit per cycle with restoring division. It returns quotient, remainder and ALU-style flags with a busy/done handshake, so the hazard unit stalls the pipeline while `busy` is high.

---
 rtl/seq_divider.sv | 200 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle restoring divider for UDIV/SDIV. It sits beside the single-cycle
// ALU and produces one quotient bit per clock. The hazard unit stalls the
// pipeline for as long as busy is high.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request, sampled on the rising edge of clk
//   A, B         dividend and divisor (WIDTH bits)
//   is_signed    1 = two's-complement divide, 0 = unsigned divide
//   busy         operation in flight (CALC/FIXUP); start is ignored meanwhile
//   done         one-cycle pulse, results valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  B was zero for the last operation
//   negative     quotient MSB
//   zero         quotient == 0
//   overflow     signed MIN / -1 occurred
//   carry_out    remainder != 0 (inexact result)
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             q_neg;
    logic             r_neg;
    logic             ovf_pend;

    logic             accept;
    logic             b_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             ovf_case;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand conditioning at the accepting edge. For unsigned operations the
    // sign bits are forced to zero, so the magnitudes are the raw operands.
    // |MIN| wraps back to MIN, which is the correct unsigned magnitude 2^(W-1).
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign b_zero   = (B == '0);
    assign a_neg    = is_signed && A[WIDTH-1];
    assign b_neg    = is_signed && B[WIDTH-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign ovf_case = is_signed && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    // One restoring step. The remainder stays below the divisor, so the shifted
    // value fits in WIDTH+1 bits. The MSB of the WIDTH+1-bit difference is set
    // exactly when the trial subtraction went negative.
    assign partial = {rem, dvd[WIDTH-1]};
    assign diff    = partial - {1'b0, dsr};

    // Sign correction applied in FIXUP. The quotient takes the XOR of the
    // operand signs and the remainder takes the sign of the dividend.
    assign q_fix = q_neg ? -dvd : dvd;
    assign r_fix = r_neg ? -rem : rem;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the busy/done decode. A zero divisor skips straight
    // to DONE. A start sampled in DONE chains directly into the next operation.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_next = b_zero ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers. The dividend register shifts left, and
    // quotient bits enter at its LSB, so after WIDTH steps it holds the
    // magnitude quotient. Results are written only on the divide-by-zero
    // accept or in FIXUP. That leaves the outputs unchanged between dones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            negative    <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            carry_out   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        dvd      <= a_mag;
                        dsr      <= b_mag;
                        rem      <= '0;
                        count    <= CW'(WIDTH - 1);
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        ovf_pend <= ovf_case;
                        if (b_zero) begin
                            quotient    <= '1;
                            remainder   <= A;
                            div_by_zero <= 1'b1;
                            negative    <= 1'b1;
                            zero        <= 1'b0;
                            overflow    <= 1'b0;
                            carry_out   <= (A != '0);
                        end
                    end
                end
                CALC: begin
                    dvd   <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
                    rem   <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    count <= count - 1'b1;
                end
                FIXUP: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= 1'b0;
                    negative    <= q_fix[WIDTH-1];
                    zero        <= (q_fix == '0);
                    overflow    <= ovf_pend;
                    carry_out   <= (r_fix != '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Directed testbench for seq_divider. A scoreboard checks the results.
// The stimulus pushes the expected result of each request into a queue. A
// monitor pops one entry per done pulse and compares it with the outputs.
// Latency and busy duration are checked by the stimulus task.
module tb_seq_divider;

    localparam int W = 64;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         neg;
        logic         zr;
        logic         ov;
        logic         co;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total;
    int   passed;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .negative    (negative),
        .zero        (zero),
        .overflow    (overflow),
        .carry_out   (carry_out)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. It records one check and reports a mismatch.
    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor. On every done pulse (sampled on the falling edge), the oldest
    // expected entry is popped and compared with the outputs.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, " quotient"},    quotient,    mon_e.q);
                checkOutput({mon_e.name, " remainder"},   remainder,   mon_e.r);
                checkOutput({mon_e.name, " div_by_zero"}, W'(div_by_zero), W'(mon_e.dz));
                checkOutput({mon_e.name, " negative"},    W'(negative),    W'(mon_e.neg));
                checkOutput({mon_e.name, " zero"},        W'(zero),        W'(mon_e.zr));
                checkOutput({mon_e.name, " overflow"},    W'(overflow),    W'(mon_e.ov));
                checkOutput({mon_e.name, " carry_out"},   W'(carry_out),   W'(mon_e.co));
            end
        end
    end

    // Issues one request and pushes its expected result.
    // Optional: a second start at cycle intrude_at, or an async reset at
    // cycle reset_at. The task returns just after the edge that raises done,
    // so a following call lands its start inside the done cycle.
    task automatic applyStimulus(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic s,
                                 input logic [W-1:0] eq, input logic [W-1:0] er,
                                 input logic edz, input logic eneg, input logic ezr,
                                 input logic eov, input logic eco,
                                 input int exp_lat, input int intrude_at,
                                 input int reset_at);
        exp_t e;
        int   cycles;
        int   busy_cycles;
        bit   aborted;
        e = '{name, eq, er, edz, eneg, ezr, eov, eco};
        exp_q.push_back(e);
        A         = a;
        B         = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        A           = ~a;
        B           = ~b;
        is_signed   = ~s;
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        aborted     = 1'b0;
        while (!done && cycles < 200 && !aborted) begin
            if (cycles == intrude_at) begin
                A         = 64'd7;
                B         = 64'd1;
                is_signed = 1'b0;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cycles == reset_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                checkOutput({name, " rst busy"},      W'(busy),        '0);
                checkOutput({name, " rst done"},      W'(done),        '0);
                checkOutput({name, " rst quotient"},  quotient,        '0);
                checkOutput({name, " rst remainder"}, remainder,       '0);
                checkOutput({name, " rst flags"},
                            W'({div_by_zero, negative, zero, overflow, carry_out}), '0);
                void'(exp_q.pop_back());
                aborted = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cycles++;
                if (busy) busy_cycles++;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end else begin
            checkOutput({name, " latency"},     W'(cycles),      W'(exp_lat));
            checkOutput({name, " busy_cycles"}, W'(busy_cycles), W'(exp_lat));
        end
    endtask

    // Directed sequence. Expected values are computed by hand. A normal
    // operation raises done 65 edges after the accepting edge (66 cycles
    // from start); divide-by-zero raises done right after the accepting edge.
    initial begin
        int done_seen;
        total     = 0;
        passed    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        is_signed = 1'b0;
        #3;
        checkOutput("reset busy",      W'(busy),  '0);
        checkOutput("reset done",      W'(done),  '0);
        checkOutput("reset quotient",  quotient,  '0);
        checkOutput("reset remainder", remainder, '0);
        checkOutput("reset flags",
                    W'({div_by_zero, negative, zero, overflow, carry_out}), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2,
                      0, 0, 0, 0, 1, 65, -1, -1);
        applyStimulus("sn100_7", -64'sd100, 64'd7, 1'b1, -64'sd14, -64'sd2,
                      0, 1, 0, 0, 1, 65, -1, -1);
        applyStimulus("s100_n7", 64'd100, -64'sd7, 1'b1, -64'sd14, 64'd2,
                      0, 1, 0, 0, 1, 65, -1, -1);
        applyStimulus("sn100_n7", -64'sd100, -64'sd7, 1'b1, 64'd14, -64'sd2,
                      0, 0, 0, 0, 1, 65, -1, -1);
        applyStimulus("s5_0", 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                      1, 1, 0, 0, 1, 0, -1, -1);
        applyStimulus("u0_0", 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                      1, 1, 0, 0, 0, 0, -1, -1);
        applyStimulus("smin_n1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                      64'h8000_0000_0000_0000, 64'd0, 0, 1, 0, 1, 0, 65, -1, -1);
        applyStimulus("umax_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 0, 0, 0, 65, -1, -1);

        // The outputs must hold while the divider sits in IDLE.
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_hold quotient",  quotient,  64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("idle_hold remainder", remainder, 64'd0);
        checkOutput("idle_hold busy",      W'(busy),  '0);
        checkOutput("idle_hold done",      W'(done),  '0);

        applyStimulus("u3_10", 64'd3, 64'd10, 1'b0, 64'd0, 64'd3,
                      0, 0, 1, 0, 1, 65, -1, -1);
        applyStimulus("umax_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0,
                      64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 0, 0, 0, 0, 1, 65, -1, -1);
        // A start raised mid-operation must be ignored.
        applyStimulus("u1000_10_intrude", 64'd1000, 64'd10, 1'b0, 64'd100, 64'd0,
                      0, 0, 0, 0, 0, 65, 10, -1);
        // Issued inside the done cycle of the previous operation.
        applyStimulus("u77_5_b2b", 64'd77, 64'd5, 1'b0, 64'd15, 64'd2,
                      0, 0, 0, 0, 1, 65, -1, -1);

        // Reset mid-operation: the request is discarded and no done may follow.
        applyStimulus("u100_7_reset", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2,
                      0, 0, 0, 0, 1, 65, -1, 30);
        done_seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("no_done_after_reset", W'(done_seen), '0);
        applyStimulus("u100_7_after_reset", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2,
                      0, 0, 0, 0, 1, 65, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
